rst_seq_ctrl: RTL and testbench
===============================

// Module: rst_seq_ctrl
// PURPOSE
//  Reset sequencer. Sits downstream of the system reset synchronizer in the always-on clock domain.
//  - Holds NUM_DOMAINS active-low domain resets asserted, then releases them one at a time, bit0 first.
//  - Each released reset feeds that domain's own reset synchronizer.
//  - Also runs software-requested re-sequencing through a four-phase REQ/ACK handshake.
// PARAMETERS
//  NUM_DOMAINS    4     number of sequenced domain resets (>=1)
//  ASSERT_CYCLES  16    cycles all domains stay in reset before the first release (>=1)
//  GAP_CYCLES     8     cycles between consecutive domain releases (>=1)
//  CNT_W          8     phase counter width; must hold max(ASSERT_CYCLES,GAP_CYCLES)-1
//  WDOG_CYCLES    1024  watchdog timeout in cycles (used only with RST_SEQ_WDOG_EN)
//  WDOG_W         16    watchdog counter width; must hold WDOG_CYCLES-1
// PORTS
//  CLK           in   1            single clock
//  RST           in   1            reset, synchronous, active-low
//  SOFT_RST_REQ  in   1            software re-sequence request (level, four-phase)
//  WDOG_KICK     in   1            watchdog service pulse (ignored without RST_SEQ_WDOG_EN)
//  DOM_RST_N     out  NUM_DOMAINS  domain resets, active-low, registered
//  ALL_RELEASED  out  1            1 while every domain is out of reset
//  BUSY          out  1            1 while a sequence is in progress (ASSERT or RELEASE state)
//  SOFT_RST_ACK  out  1            handshake acknowledge
//  WDOG_EXPIRED  out  1            one-cycle pulse on watchdog timeout
// BEHAVIOUR
//  - RST=0 at a CLK edge forces:
//    state=ASSERT, cnt=0, idx=0
//    DOM_RST_N=0, ALL_RELEASED=0, BUSY=1, SOFT_RST_ACK=0, WDOG_EXPIRED=0
//    This applies in any state, mid-sequence included: the next edge restarts from ASSERT.
//  - Edge numbering: edge 1 is the first edge at which RST=1 is sampled.
//  - ASSERT state:
//    cnt counts 0..ASSERT_CYCLES-1, then state=RELEASE with cnt=0.
//  - RELEASE state:
//    cnt counts 0..GAP_CYCLES-1; at cnt=GAP_CYCLES-1, DOM_RST_N[idx]<=1 and idx++.
//    Result: DOM_RST_N[k] rises at edge ASSERT_CYCLES+(k+1)*GAP_CYCLES.
//    On the last domain, at that same edge: ALL_RELEASED<=1, BUSY<=0, state=RUN.
//    Released bits stay 1 until the next sequence starts.
//  - RUN state:
//    SOFT_RST_REQ=1 and SOFT_RST_ACK=0 sampled -> next edge: DOM_RST_N=0, ALL_RELEASED=0, BUSY=1,
//    cnt=0, idx=0, state=ASSERT. Timing then matches power-up.
//  - SOFT_RST_ACK:
//    Set at the sequence-completion edge if SOFT_RST_REQ=1 is sampled at that edge.
//    Cleared at the first edge that samples SOFT_RST_REQ=0.
//    New request requires REQ 0 then 1; REQ held high after ACK starts nothing.
//    REQ dropped mid-sequence: sequence completes, ACK stays 0.
//    REQ sampled during ASSERT/RELEASE never restarts the sequence.
//  - Outputs change only on CLK edges; no combinational input-to-output paths.
// CONFIGURATION
//  Macro RST_SEQ_WDOG_EN, defined:
//  - Watchdog counter runs in RUN only; cleared to 0 on entering RUN and on any cycle with WDOG_KICK=1.
//  - Counter=WDOG_CYCLES-1 with WDOG_KICK=0 sampled -> next edge:
//    WDOG_EXPIRED=1 (one cycle), counter=0, same restart as a soft request.
//  - Expiry and a soft request at the same edge produce one sequence; ACK follows the REQ rules above.
//  Macro not defined:
//  - No watchdog logic; WDOG_KICK ignored; WDOG_EXPIRED tied 0.
// TESTING (defaults unless stated)
//  1 Power-up: RST=0 5 cycles then 1 -> DOM_RST_N=0000 to edge 23; 0001@24, 0011@32, 0111@40,
//    1111@48; ALL_RELEASED=1 and BUSY=0 @48.
//  2 Soft reset: in RUN raise REQ -> next edge DOM_RST_N=0000, BUSY=1; 1111 and ACK=1 48 edges later;
//    drop REQ -> ACK=0 next edge.
//  3 REQ held high 200 cycles after ACK -> no second sequence; REQ 0 then 1 -> new sequence.
//  4 RST=0 at edge 35 (DOM_RST_N=0011) -> 0000 next edge; after release, full 48-edge sequence again.
//  5 NUM_DOMAINS=1, ASSERT_CYCLES=1, GAP_CYCLES=1 -> DOM_RST_N=1 and ALL_RELEASED=1 at edge 2.
//  6 WDOG on, WDOG_CYCLES=64: no kick 64 cycles in RUN -> 1-cycle WDOG_EXPIRED, DOM=0000, re-sequence;
//    kick every 32 cycles -> no expiry; macro off -> WDOG_EXPIRED always 0.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_ctrl
// Brief    : Reset sequencer. Holds all domain resets low, then releases them
//            one at a time (bit 0 first), with a REQ/ACK soft re-sequence.
//            Optional watchdog restart enabled by macro RST_SEQ_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS   = 4,
  parameter int ASSERT_CYCLES = 16,
  parameter int GAP_CYCLES    = 8,
  parameter int CNT_W         = 8,
  parameter int WDOG_CYCLES   = 1024,
  parameter int WDOG_W        = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   soft_rst_req_i,
  input  logic                   wdog_kick_i,
  output logic [NUM_DOMAINS-1:0] dom_rst_n_o,
  output logic                   all_released_o,
  output logic                   busy_o,
  output logic                   soft_rst_ack_o,
  output logic                   wdog_expired_o
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   all_rel_q, all_rel_d;
  logic                   busy_q, busy_d;
  logic                   ack_q, ack_d;
  logic                   wexp_q, wexp_d;
  logic                   w_wdog_fire;
  logic [NUM_DOMAINS-1:0] w_idx_onehot;

`ifdef RST_SEQ_WDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Counter is held at zero outside RUN, so entering RUN always starts fresh.
  always_comb begin
    wdog_d      = '0;
    w_wdog_fire = 1'b0;
    if (state_q == ST_RUN && !wdog_kick_i) begin
      if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
        w_wdog_fire = 1'b1;
      end else begin
        wdog_d = wdog_q + WDOG_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic              unused_kick;
  logic [WDOG_W-1:0] unused_wdog_cfg;

  assign w_wdog_fire     = 1'b0;
  assign unused_kick     = wdog_kick_i;
  assign unused_wdog_cfg = WDOG_W'(WDOG_CYCLES - 1);
`endif

  always_comb begin
    w_idx_onehot = '0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      w_idx_onehot[k] = (idx_q == IDX_W'(k));
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dom_d     = dom_q;
    all_rel_d = all_rel_q;
    busy_d    = busy_q;
    ack_d     = ack_q;
    wexp_d    = 1'b0;

    // ACK drops on the first low REQ regardless of state.
    if (!soft_rst_req_i) begin
      ack_d = 1'b0;
    end

    case (state_q)
      ST_ASSERT: begin
        if (cnt_q == CNT_W'(ASSERT_CYCLES - 1)) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          dom_d = dom_q | w_idx_onehot;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
            idx_d     = '0;
            all_rel_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_RUN;
            if (soft_rst_req_i) begin
              ack_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // A fresh request (ACK low) and a watchdog expiry share one restart.
        if ((soft_rst_req_i && !ack_q) || w_wdog_fire) begin
          state_d   = ST_ASSERT;
          cnt_d     = '0;
          idx_d     = '0;
          dom_d     = '0;
          all_rel_d = 1'b0;
          busy_d    = 1'b1;
          wexp_d    = w_wdog_fire;
        end
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      dom_q     <= '0;
      all_rel_q <= 1'b0;
      busy_q    <= 1'b1;
      ack_q     <= 1'b0;
      wexp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dom_q     <= dom_d;
      all_rel_q <= all_rel_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      wexp_q    <= wexp_d;
    end
  end

  assign dom_rst_n_o    = dom_q;
  assign all_released_o = all_rel_q;
  assign busy_o         = busy_q;
  assign soft_rst_ack_o = ack_q;
  assign wdog_expired_o = wexp_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq_ctrl
// Brief    : Scoreboard bench for rst_seq_ctrl; timeline-based reference model.
//            Watchdog modelling follows macro RST_SEQ_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_seq_ctrl;

  localparam int N  = 4;
  localparam int A  = 16;
  localparam int G  = 8;
  localparam int WD = 1024;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         req   = 1'b0;
  logic         kick  = 1'b0;
  logic [N-1:0] dom;
  logic         all_rel, busy, ack, wexp;
  bit           kick_en = 1'b0;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .NUM_DOMAINS  (N),
    .ASSERT_CYCLES(A),
    .GAP_CYCLES   (G),
    .CNT_W        (8),
    .WDOG_CYCLES  (WD),
    .WDOG_W       (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .soft_rst_req_i(req),
    .wdog_kick_i   (kick),
    .dom_rst_n_o   (dom),
    .all_released_o(all_rel),
    .busy_o        (busy),
    .soft_rst_ack_o(ack),
    .wdog_expired_o(wexp)
  );

  typedef struct packed {
    logic [N-1:0] dom;
    logic         all_rel;
    logic         busy;
    logic         ack;
    logic         wexp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   wexp_seen = 1'b0;

  // Reference: t = edges since the current sequence started; domain k is
  // out of reset once t reaches A+(k+1)*G, and RUN begins at A+N*G.
  int t      = 0;
  bit run    = 1'b0;
  bit m_ack  = 1'b0;
  bit m_wexp = 1'b0;
  int wcnt   = 0;

  always @(posedge clk) begin : model
    bit   fire_s;
    bit   fire_w;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      t = 0; run = 1'b0; m_ack = 1'b0; m_wexp = 1'b0; wcnt = 0;
    end else begin
      m_wexp = 1'b0;
      if (!run) begin
        t++;
        if (t == A + N * G) begin
          run  = 1'b1;
          wcnt = 0;
          if (req) m_ack = 1'b1;
        end
        if (!req) m_ack = 1'b0;
      end else begin
        fire_s = req && !m_ack;
        fire_w = 1'b0;
`ifdef RST_SEQ_WDOG_EN
        if (kick) wcnt = 0;
        else if (wcnt == WD - 1) begin fire_w = 1'b1; wcnt = 0; end
        else wcnt++;
`endif
        if (!req) m_ack = 1'b0;
        if (fire_s || fire_w) begin
          run = 1'b0; t = 0; wcnt = 0; m_wexp = fire_w;
        end
      end
    end
    for (int k = 0; k < N; k++) e.dom[k] = (t >= A + (k + 1) * G);
    e.all_rel = run;
    e.busy    = !run;
    e.ack     = m_ack;
    e.wexp    = m_wexp;
    q.push_back(e);
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    exp_t got;
    #1;
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = {dom, all_rel, busy, ack, wexp};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got dom=%b all_rel=%b busy=%b ack=%b wexp=%b, expected dom=%b all_rel=%b busy=%b ack=%b wexp=%b",
                 cyc, got.dom, got.all_rel, got.busy, got.ack, got.wexp,
                 e.dom, e.all_rel, e.busy, e.ack, e.wexp);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      kick = kick_en && ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    kick_en = 1'b1;
    rst_n = 1'b0; req = 1'b0;
    step(5);
    checks++;
    if (dom !== '0 || all_rel !== 1'b0 || busy !== 1'b1 || ack !== 1'b0 || wexp !== 1'b0) begin
      errors++;
      $display("FAIL reset state: dom=%b all_rel=%b busy=%b ack=%b wexp=%b",
               dom, all_rel, busy, ack, wexp);
    end
    rst_n = 1'b1;
    step(60);
    // soft re-sequence, then REQ held high well past ACK
    req = 1'b1;
    step(60);
    step(200);
    req = 1'b0;
    step(3);
    // new request, interrupted mid-release by the system reset
    req = 1'b1;
    step(35);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(60);
    req = 1'b0;
    step(5);
    // long stretch without watchdog service
    kick_en = 1'b0;
    wexp_seen = 1'b0;
    for (int w = 0; w < 1100; w++) begin
      step(1);
      if (wexp === 1'b1) wexp_seen = 1'b1;
    end
    checks++;
`ifdef RST_SEQ_WDOG_EN
    if (!wexp_seen) begin
      errors++;
      $display("FAIL watchdog: no WDOG_EXPIRED pulse within 1100 unserviced cycles");
    end
`else
    if (wexp_seen) begin
      errors++;
      $display("FAIL watchdog: WDOG_EXPIRED asserted with watchdog disabled");
    end
`endif
    kick_en = 1'b1;
    // random request toggling with occasional system resets
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if ($urandom_range(0, 39) == 0) req = ~req;
      rst_n = ($urandom_range(0, 699) != 0);
    end
    rst_n = 1'b1;
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
